// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
//
// Parametrised APB3/APB4 register-file slave: a bank of DEPTH words of DATA_W
// bits with byte-strobed writes, configurable access-phase wait states,
// registered read data and an error response on out-of-range or misaligned
// accesses.
//
// Parameters
//   DATA_W      data bus width (8, 16, 32 or 64)
//   ADDR_W      byte-address width of paddr
//   DEPTH       number of DATA_W words, DEPTH <= 2^(ADDR_W - log2(DATA_W/8))
//   WAIT_CYCLES pready-low cycles inserted in the access phase (0..15)
//
// Ports
//   pclk     in   clock, all state changes on the rising edge
//   preset   in   synchronous active-high reset (also clears the memory)
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pstrb    in   byte-lane write enables (tie all-ones for APB3 masters)
//   prdata   out  read data, nonzero only while pready=1 on a legal read
//   pready   out  transfer-complete handshake
//   pslverr  out  error response, valid only while pready=1
// -----------------------------------------------------------------------------
module apb_regfile_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                illegal_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                setup_illegal;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_write;
  logic                cur_illegal;
  logic [MEM_AW-1:0]   mem_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                wr_commit;

  // Out-of-range word index or nonzero byte offset within the word.
  function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = a >> OFF_W;
    return (32'(idx) >= 32'(DEPTH)) || ((a & OFF_MASK) != '0);
  endfunction

  assign setup_illegal = addr_illegal(paddr);

  // With zero wait states pready is raised on the setup edge itself, so the
  // read word must come from the live bus; otherwise from the latched request.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    cur_addr    = addr_q;
    cur_write   = write_q;
    cur_illegal = illegal_q;
    if (state == IDLE) begin
      cur_addr    = paddr;
      cur_write   = pwrite;
      cur_illegal = setup_illegal;
    end
    mem_idx = MEM_AW'(cur_addr >> OFF_W);
    rd_word = '0;
    if (!cur_write && !cur_illegal) begin
      rd_word = mem[mem_idx];
    end
  end

  // A legal write commits only on the completing edge in RESP.
  assign wr_commit = (state == RESP) && psel && penable && write_q && !illegal_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            addr_q    <= paddr;
            write_q   <= pwrite;
            illegal_q <= setup_illegal;
            cnt       <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= setup_illegal;
              prdata  <= rd_word;
            end else begin
              state <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (!psel) begin
            // Master abandoned the transfer before completion.
            state   <= IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end else if (cnt > CNT_W'(1)) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Last wait cycle: the counter reaches zero on this edge and
            // pready rises together with it.
            cnt     <= '0;
            state   <= RESP;
            pready  <= 1'b1;
            pslverr <= illegal_q;
            prdata  <= rd_word;
          end
        end

        RESP: begin
          // Completion (psel & penable) and abort (~psel) both end the
          // transfer; the memory block decides whether a write commits.
          if (!psel || penable) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
      endcase
    end
  end

  // NOTE: the register bank is cleared by reset because it is a flop array
  // whose reset value is architecturally visible; a RAM macro would not be.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (pstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_regfile_slave
//
// Three slaves (WAIT_CYCLES = 0, 2, 3) share one APB bus, each with its own
// psel. A transfer-level model keeps one word array per slave and, for every
// cycle of a transfer, states what pready/pslverr/prdata must show; a compare
// process checks all three slaves against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_apb_regfile_slave;

  localparam int WAITS [3] = '{0, 2, 3};

  logic        pclk;
  logic        preset;
  logic        sel [3];
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        rdy  [3];
  logic        err  [3];
  logic [31:0] rdat [3];

  // Model state and per-cycle expectations.
  logic [31:0] mmem    [3][32];
  logic        exp_rdy [3];
  logic        exp_err [3];
  logic [31:0] exp_dat [3];
  bit          chk_en;

  int n_checks = 0;
  int n_fail   = 0;

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(rdat[0]), .pready(rdy[0]), .pslverr(err[0])
  );

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(2)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(rdat[1]), .pready(rdy[1]), .pslverr(err[1])
  );

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(3)) u_dut2 (
    .pclk(pclk), .preset(preset), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(rdat[2]), .pready(rdy[2]), .pslverr(err[2])
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic bit is_illegal(input logic [7:0] a);
    return (a[1:0] != 2'b00) || (a[7:2] >= 6'd32);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++)
        mmem[d][i] = 32'h0;
  endtask

  task automatic model_write(input int d, input logic [7:0] a, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [4:0] idx;
    idx = a[6:2];
    for (int b = 0; b < 4; b++)
      if (strb[b]) mmem[d][idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic clear_exp(input int d);
    exp_rdy[d] = 1'b0;
    exp_err[d] = 1'b0;
    exp_dat[d] = 32'h0;
  endtask

  // Expected outputs during access cycle k (1-based) of a transfer: the
  // response appears in access cycle WAIT+1 and nowhere earlier.
  task automatic set_exp(input int d, input int k, input bit wr, input logic [7:0] a);
    logic [4:0] idx;
    bit         last;
    idx  = a[6:2];
    last = (k == WAITS[d] + 1);
    clear_exp(d);
    if (last) begin
      exp_rdy[d] = 1'b1;
      exp_err[d] = is_illegal(a);
      if (!wr && !is_illegal(a)) exp_dat[d] = mmem[d][idx];
    end
  endtask

  // One APB transfer on slave d. abort_at >= 0 drops psel after that many
  // access cycles; rst_at > 0 raises preset in that access cycle instead.
  // rd/er are the DUT outputs sampled in the response cycle.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] data, input logic [3:0] strb,
                      input int abort_at, input int rst_at,
                      output logic [31:0] rd, output logic er);
    int w;
    w  = WAITS[d];
    rd = 32'h0;
    er = 1'b0;
    sel[d]  = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = data;
    pstrb   = strb;
    clear_exp(d);
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int k = 1; k <= w + 1; k++) begin
      set_exp(d, k, wr, a);
      if (k == rst_at) begin
        preset  = 1'b1;
        sel[d]  = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        model_reset();
        clear_exp(d);
        return;
      end
      if (k == abort_at + 1) begin
        sel[d]  = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        clear_exp(d);
        return;
      end
      if (k == w + 1) begin
        rd = rdat[d];
        er = err[d];
      end
      @(posedge pclk); #1;
    end
    if (wr && !is_illegal(a)) model_write(d, a, data, strb);
    sel[d]  = 1'b0;
    penable = 1'b0;
    clear_exp(d);
  endtask

  // Cycle-by-cycle comparison of every slave against the model.
  always @(negedge pclk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("cyc_d%0d_pready", d),  64'(rdy[d]),  64'(exp_rdy[d]));
        check($sformatf("cyc_d%0d_pslverr", d), 64'(err[d]),  64'(exp_err[d]));
        check($sformatf("cyc_d%0d_prdata", d),  64'(rdat[d]), 64'(exp_dat[d]));
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          d, ab;
    bit          wr;
    logic [7:0]  a;

    chk_en  = 1'b0;
    preset  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h0;
    pwdata  = 32'h0;
    pstrb   = 4'h0;
    for (int i = 0; i < 3; i++) begin
      sel[i] = 1'b0;
      clear_exp(i);
    end
    model_reset();

    // Reset held for two cycles.
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_d%0d_outputs", i), {rdy[i], err[i], rdat[i]}, 64'h0);
    end

    // Read after reset, zero wait states.
    xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, -1, 0, rd, er);
    check("reset_read_prdata", rd, 32'h0);
    check("reset_read_pslverr", er, 1'b0);

    // Write then read with two wait states.
    xfer(1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, -1, 0, rd, er);
    xfer(1, 1'b0, 8'h04, 32'h0, 4'hF, -1, 0, rd, er);
    check("wait2_read_0x04", rd, 32'hDEADBEEF);

    // Byte strobes.
    xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, -1, 0, rd, er);
    xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'h5, -1, 0, rd, er);
    check("model_strobe_word", mmem[0][2], 32'h11BB33DD);
    xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, -1, 0, rd, er);
    check("strobe_read_0x08", rd, 32'h11BB33DD);

    // Out-of-range read.
    xfer(0, 1'b0, 8'h80, 32'h0, 4'hF, -1, 0, rd, er);
    check("oor_read_pslverr", er, 1'b1);
    check("oor_read_prdata", rd, 32'h0);

    // Misaligned write must not touch any word.
    xfer(0, 1'b1, 8'h00, 32'hCAFE0001, 4'hF, -1, 0, rd, er);
    xfer(0, 1'b1, 8'h81, 32'hFFFFFFFF, 4'hF, -1, 0, rd, er);
    check("misaligned_wr_pslverr", er, 1'b1);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, -1, 0, rd, er);
    check("misaligned_wr_kept_0x00", rd, 32'hCAFE0001);

    // Abort after one access cycle, three wait states.
    xfer(2, 1'b1, 8'h0C, 32'h0BADF00D, 4'hF, -1, 0, rd, er);
    xfer(2, 1'b1, 8'h0C, 32'h12345678, 4'hF, 1, 0, rd, er);
    xfer(2, 1'b0, 8'h0C, 32'h0, 4'hF, -1, 0, rd, er);
    check("abort_kept_0x0C", rd, 32'h0BADF00D);

    // Reset in the middle of an access.
    xfer(2, 1'b1, 8'h0C, 32'h12345678, 4'hF, -1, 2, rd, er);
    check("midrst_pready", rdy[2], 1'b0);
    check("midrst_pslverr", err[2], 1'b0);
    check("midrst_prdata", rdat[2], 32'h0);
    xfer(2, 1'b0, 8'h0C, 32'h0, 4'hF, -1, 0, rd, er);
    check("midrst_mem3_cleared", rd, 32'h0);

    // Back-to-back writes then reads with no idle cycle between transfers.
    for (int i = 0; i < 32; i++) begin
      xfer(0, 1'b1, 8'(i * 4), 32'(i), 4'hF, -1, 0, rd, er);
    end
    for (int i = 0; i < 32; i++) begin
      xfer(0, 1'b0, 8'(i * 4), 32'h0, 4'hF, -1, 0, rd, er);
      check($sformatf("b2b_read_idx%0d", i), rd, 32'(i));
    end

    // Randomized traffic across all three slaves.
    for (int n = 0; n < 300; n++) begin
      d  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) a = {3'($urandom_range(0, 7) & 0), 5'($urandom_range(0, 31)), 2'b00} >> 0;
      else                           a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ab = $urandom_range(0, WAITS[d]);
      else                           ab = -1;
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), ab, 0, rd, er);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge pclk); #1;
      end
    end

    chk_en = 1'b0;
    repeat (2) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
